// File: rtl/complex_nr_pkg.sv
// complex_nr_pkg: shared state encoding and width helpers for the complex accumulator
package complex_nr_pkg;
  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;
  function automatic int acc_w(int dw, int gb);
    return 2 * dw + gb;
  endfunction
  function automatic int cnt_w(int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/complex_acc_lane.sv
// complex_acc_lane: signed sign-extend-and-accumulate register with clear
module complex_acc_lane #(
  parameter int IW = 16,
  parameter int OW = 20
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] d,
  output logic [OW-1:0] sum
);
  logic [OW-1:0] acc;
  assign sum = en ? acc + OW'($signed(d)) : acc;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) acc <= '0;
    else acc <= clr ? '0 : sum;
endmodule

// File: rtl/complex_nr_acc.sv
// complex_nr_acc: accumulates ACC_LEN complex products into one framed complex sum
module complex_nr_acc
  import complex_nr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN = 4,
  parameter int GUARD_BITS = 4,
  localparam int ACC_W = acc_w(DATA_WIDTH, GUARD_BITS),
  localparam int CW = cnt_w(ACC_LEN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    in_val,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_re,
  input  logic [2*DATA_WIDTH-1:0] in_im,
  input  logic                    flush,
  output logic                    out_val,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_re,
  output logic [ACC_W-1:0]        out_im,
  output logic [CW-1:0]           out_cnt
);
  if (ACC_LEN < 1 || ACC_LEN > 2**GUARD_BITS) begin : g_bad_len
    $error("complex_nr_acc: ACC_LEN out of range 1..2**GUARD_BITS");
  end
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic beat, close;
  logic [ACC_W-1:0] sum_re, sum_im;
  assign in_ready = state == ST_ACCUM;
  assign out_val = state == ST_HOLD;
  assign beat = in_val && in_ready;
  assign cnt_nxt = cnt + CW'(beat);
  // cnt_nxt cannot wrap in ACCUM, so nonzero means at least one product is in the frame
  assign close = in_ready && ((beat && cnt == CW'(ACC_LEN - 1)) || (flush && cnt_nxt != '0));
  complex_acc_lane #(.IW(2*DATA_WIDTH), .OW(ACC_W)) u_re (
    .clk(clk), .rstn(rstn), .clr(sw_rst || close), .en(beat), .d(in_re), .sum(sum_re)
  );
  complex_acc_lane #(.IW(2*DATA_WIDTH), .OW(ACC_W)) u_im (
    .clk(clk), .rstn(rstn), .clr(sw_rst || close), .en(beat), .d(in_im), .sum(sum_im)
  );
  always_comb
    state_nxt = sw_rst ? ST_ACCUM : close ? ST_HOLD : (out_val && out_ready) ? ST_ACCUM : state;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ST_ACCUM;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= (sw_rst || close) ? '0 : cnt_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_re <= '0;
      out_im <= '0;
      out_cnt <= '0;
    end else if (sw_rst) begin
      out_re <= '0;
      out_im <= '0;
      out_cnt <= '0;
    end else if (close) begin
      out_re <= sum_re;
      out_im <= sum_im;
      out_cnt <= cnt_nxt;
    end
endmodule

// File: tb/tb_complex_nr_acc.sv
// tb_complex_nr_acc: scoreboard bench with a frame-level reference model for complex_nr_acc
module tb_complex_nr_acc;
  localparam int DW = 8, AL = 4, GB = 4, AW = 2*DW + GB, CW = $clog2(AL + 1);
  typedef struct {logic [AW-1:0] re; logic [AW-1:0] im; logic [CW-1:0] cnt;} exp_t;
  logic clk = 0, rstn = 0, sw_rst = 0, in_val = 0, flush = 0, out_ready = 0;
  logic [2*DW-1:0] in_re = '0, in_im = '0;
  logic in_ready, out_val;
  logic [AW-1:0] out_re, out_im;
  logic [CW-1:0] out_cnt;
  int cmp = 0, err = 0;
  exp_t q[$];
  int fr_re = 0, fr_im = 0, fr_n = 0;
  bit hold = 0;

  complex_nr_acc #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(GB)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .in_val(in_val), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .flush(flush), .out_val(out_val), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    cmp++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // one cycle: check handshake flags of the last edge, drive inputs, advance the model
  task automatic step(bit v, logic [15:0] re, logic [15:0] im, bit fl, bit ordy, bit sr);
    @(posedge clk);
    #2;
    chk("in_ready", 32'(in_ready), 32'(!hold));
    chk("out_val", 32'(out_val), 32'(hold));
    in_val = v; in_re = re; in_im = im; flush = fl; out_ready = ordy; sw_rst = sr;
    if (sr) begin
      fr_re = 0; fr_im = 0; fr_n = 0; hold = 0;
      q.delete();
    end else if (!hold) begin
      if (v) begin
        fr_re += int'($signed(re));
        fr_im += int'($signed(im));
        fr_n++;
      end
      if (fr_n == AL || (fl && fr_n > 0)) begin
        q.push_back('{re: AW'(fr_re), im: AW'(fr_im), cnt: CW'(fr_n)});
        fr_re = 0; fr_im = 0; fr_n = 0; hold = 1;
      end
    end else if (ordy) hold = 0;
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, ordy, 0);
  endtask

  always @(negedge clk)
    if (rstn && !sw_rst && out_val) begin
      if (q.size() == 0) begin
        cmp++; err++;
        $display("FAIL spurious_out: got out_val=1, expected no pending frame");
      end else begin
        chk("out_re", 32'(out_re), 32'(q[0].re));
        chk("out_im", 32'(out_im), 32'(q[0].im));
        chk("out_cnt", 32'(out_cnt), 32'(q[0].cnt));
        if (out_ready) void'(q.pop_front());
      end
    end

  initial begin
    #12 rstn = 1;
    #1;
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_re", 32'(out_re), 0);
    chk("rst_out_im", 32'(out_im), 0);
    chk("rst_out_cnt", 32'(out_cnt), 0);
    step(1, 16'd1, 16'd2, 0, 1, 0);
    step(1, 16'd3, 16'hFFFC, 0, 1, 0);
    step(1, 16'hFFFF, 16'd5, 0, 1, 0);
    step(1, 16'd100, 16'd0, 0, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 4; i++) step(1, 16'h8000, 16'h7FFF, 0, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 4; i++) step(1, 16'(i + 7), 16'(i * 3), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h1234, 16'h4321, 0, 0, 0);
    step(1, 16'd9, 16'd9, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 16'd2, 16'hFFFE, 0, 1, 0);
    idle(2, 1);
    step(1, 16'd5, 16'd5, 0, 1, 0);
    step(1, 16'd6, 16'd6, 0, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    idle(2, 1);
    step(1, 16'd1, 16'd1, 0, 1, 0);
    step(1, 16'd2, 16'd2, 0, 1, 0);
    step(1, 16'd3, 16'd3, 1, 1, 0);
    idle(2, 1);
    step(0, '0, '0, 1, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 16'd50, 16'd60, 0, 1, 0);
    step(0, '0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 16'd1, 16'd1, 0, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, 16'($urandom), 16'($urandom), $urandom_range(9) == 0,
           $urandom_range(4) > 1, $urandom_range(49) == 0);
    idle(3, 1);
    for (int i = 0; i < 4; i++) step(1, 16'd77, 16'hFF00, 0, 0, 0);
    idle(2, 0);
    @(posedge clk);
    #2;
    chk("pre_rstn_hold", 32'(out_val), 1);
    rstn = 0;
    #1;
    chk("arst_out_val", 32'(out_val), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_re", 32'(out_re), 0);
    chk("arst_out_im", 32'(out_im), 0);
    chk("arst_out_cnt", 32'(out_cnt), 0);
    q.delete();
    fr_re = 0; fr_im = 0; fr_n = 0; hold = 0;
    in_val = 0;
    #10 rstn = 1;
    for (int i = 0; i < 4; i++) step(1, 16'd1, 16'd1, 0, 1, 0);
    idle(3, 1);
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/complex_nr_acc.md
Name: complex_nr_acc

Overview:
- Downstream stage of the complex multiplier.
- Consumes the multiplier's result stream (result_re/result_im under a res_val/res_ready handshake) and accumulates ACC_LEN complex products into one complex sum, i.e. a complex dot product.
- Presents the frame sum on a valid/ready output handshake, then starts the next frame.
- Supports early frame termination (flush) and software reset.

Parameters:
- DATA_WIDTH, 8: operand width of the upstream multiplier. Input samples are 2*DATA_WIDTH bits wide.
- ACC_LEN, 4: number of products per frame. Legal range 1 to 2**GUARD_BITS.
- GUARD_BITS, 4: extra accumulator MSBs. Output width is ACC_W = 2*DATA_WIDTH + GUARD_BITS.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- sw_rst  input  1  software reset, synchronous, active-high.
- in_val  input  1  input product valid. Driven by the upstream res_val.
- in_ready  output  1  block accepts a product. Drives the upstream res_ready.
- in_re  input  2*DATA_WIDTH  real part of the product, two's complement.
- in_im  input  2*DATA_WIDTH  imaginary part of the product, two's complement.
- flush  input  1  close the current frame early. Sampled every cycle.
- out_val  output  1  frame sum valid.
- out_ready  input  1  consumer accepts the sum.
- out_re  output  ACC_W  accumulated real sum, two's complement.
- out_im  output  ACC_W  accumulated imaginary sum, two's complement.
- out_cnt  output  $clog2(ACC_LEN+1)  number of products in the emitted frame.

Behaviour:
- Reset on rstn low (asynchronous) or sw_rst high (synchronous; sw_rst has priority over every other event):
  - State goes to ACCUM.
  - Accumulators, count, out_re, out_im and out_cnt are cleared to 0.
  - out_val = 0.
  - A partial frame is discarded; a pending output is dropped.
- States: ACCUM and HOLD. in_ready = (state == ACCUM). out_val = (state == HOLD). Both are registered-state decodes with no combinational path from inputs.
- Beat: in_val && in_ready. On a beat:
  - acc_re += sign_extend(in_re) to ACC_W bits; acc_im likewise; cnt += 1.
  - Arithmetic is modulo 2**ACC_W. With ACC_LEN <= 2**GUARD_BITS, overflow cannot occur.
- Frame close in ACCUM, on either condition:
  - a beat with cnt == ACC_LEN-1, or
  - flush == 1 with cnt + beat >= 1.
- On frame close (next edge):
  - out_re/out_im are loaded with the sum including the current beat; out_cnt is loaded with the final count.
  - State goes to HOLD.
  - Accumulators and cnt are cleared.
  - Latency: out_val rises 1 cycle after the closing beat.
- flush in the same cycle as a beat: the beat is included, then the frame closes.
- flush with cnt == 0 and no beat: ignored. No empty frames are ever emitted.
- flush in HOLD: ignored.
- HOLD:
  - out_re, out_im and out_cnt are stable while out_val = 1 and out_ready = 0.
  - in_val is ignored (in_ready = 0), which back-pressures the multiplier.
  - On out_val && out_ready: state goes to ACCUM at the next edge; outputs keep their values but are no longer valid.
  - No beat is accepted in the handshake cycle itself.
- Throughput: an ACC_LEN-beat frame with out_ready held high takes ACC_LEN+1 cycles.
- Elaboration must fail if ACC_LEN < 1 or ACC_LEN > 2**GUARD_BITS.

Decomposition:
- Shared package complex_nr_pkg holds:
  - state encoding (ST_ACCUM = 1'b0, ST_HOLD = 1'b1);
  - the ACC_W derivation function;
  - the count-width helper.
- One natural sub-module: complex_acc_lane. It is a single signed sign-extend-and-accumulate register with clear and load controls, instantiated twice (re, im).
- The FSM, counter and output registers stay in the top.

Test Plan:
- Nominal frame: DATA_WIDTH=8, ACC_LEN=4, out_ready=1. Beats (re,im) = (1,2), (3,0xFFFC), (0xFFFF,5), (100,0). Expected: out_re=103, out_im=3, out_cnt=4; out_val high exactly 1 cycle, 1 cycle after beat 4.
- Extremes: 4 beats of (0x8000,0x7FFF). Expected: out_re=20'hE0000 (-131072), out_im=20'h1FFFC (131068); no wrap.
- Back-pressure: frame complete, out_ready=0 for 5 cycles, in_val=1 throughout. Expected: in_ready=0, no beats consumed, outputs stable. Then out_ready=1: 1-cycle handshake, in_ready=1 next cycle, next frame starts from 0.
- Flush:
  - 2 beats (5,5), (6,6), then flush alone: out_re=11, out_im=11, out_cnt=2.
  - flush together with beat 3: out_cnt=3.
  - flush with cnt=0: no out_val.
- Resets:
  - sw_rst after 3 beats: next 4-beat frame of (1,1) gives out_re=4 (no leftover).
  - rstn low during HOLD: out_val drops asynchronously, all outputs read 0.
